// File: rtl/snake_pkg.sv
// Shared encodings for the snake game controller: game states, movement
// directions, key bit positions and the default move-tick divisor.
package snake_pkg;

    // Game states
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    // Movement directions; reverse pairs differ only in bit 0
    localparam logic [1:0] DIR_UP = 2'b00;
    localparam logic [1:0] DIR_DN = 2'b01;
    localparam logic [1:0] DIR_LF = 2'b10;
    localparam logic [1:0] DIR_RT = 2'b11;

    // Bit positions of the key inputs inside the synchroniser vector
    localparam int unsigned KEY_S    = 0;
    localparam int unsigned KEY_P    = 1;
    localparam int unsigned KEY_R    = 2;
    localparam int unsigned KEY_ESC  = 3;
    localparam int unsigned KEY_UP   = 4;
    localparam int unsigned KEY_DN   = 5;
    localparam int unsigned KEY_LF   = 6;
    localparam int unsigned KEY_RT   = 7;
    localparam int unsigned NUM_KEYS = 8;

    // 100 MHz / 10 Hz move rate
    localparam int unsigned MOVE_DIV_DEFAULT = 10000000;

    // True when 'req' points straight back along 'cur' (UP<->DN, LF<->RT).
    function automatic logic is_reverse(input logic [1:0] req, input logic [1:0] cur);
        return (req[1] == cur[1]) && (req[0] != cur[0]);
    endfunction

endpackage

// File: rtl/snake_game_ctrl_key_edge_sync.sv
// Per-key two-flop synchroniser followed by a registered rising-edge
// detector. A key rising before edge N yields a one-cycle event after
// edge N+2, however long the key stays high.
module key_edge_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W-1:0] key_async,
    output logic [W-1:0] key_event
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_key
            logic meta_reg;
            logic sync_reg;
            logic prev_reg;
            logic event_reg;

            // Synchronise the asynchronous key and emit one pulse per rising edge
            always_ff @(posedge clk) begin
                if (srst) begin
                    meta_reg  <= 1'b0;
                    sync_reg  <= 1'b0;
                    prev_reg  <= 1'b0;
                    event_reg <= 1'b0;
                end else begin
                    meta_reg  <= key_async[gi];
                    sync_reg  <= meta_reg;
                    prev_reg  <= sync_reg;
                    event_reg <= sync_reg & ~prev_reg;
                end
            end

            assign key_event[gi] = event_reg;
        end
    endgenerate

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: turns keyboard pulses into game state, committed
// movement direction, the periodic move tick and the board-clear pulse.
// MOVE_DIV must be at least 2 and fit in CTR_W bits.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned MOVE_DIV = MOVE_DIV_DEFAULT,
    parameter int unsigned CTR_W    = 24
) (
    input  logic       clk100Mhz,
    input  logic       reset,
    input  logic       s,
    input  logic       p,
    input  logic       r,
    input  logic       esc,
    input  logic       up,
    input  logic       dn,
    input  logic       lf,
    input  logic       rt,
    input  logic       collide,
    output logic [1:0] state,
    output logic [1:0] dir,
    output logic       move_tick,
    output logic       clear,
    output logic       running
);

    localparam logic [CTR_W-1:0] CNT_LAST = CTR_W'(MOVE_DIV - 1);
    localparam logic [CTR_W-1:0] CNT_ONE  = CTR_W'(1);

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_evt;

    logic [1:0]       state_reg,   state_next;
    logic [1:0]       dir_reg,     dir_next;
    logic [1:0]       pending_reg, pending_next;
    logic [CTR_W-1:0] cnt_reg,     cnt_next;
    logic             tick_reg,    tick_next;
    logic             clear_reg,   clear_next;

    logic       dir_valid;
    logic [1:0] dir_sel;

    assign key_raw[KEY_S]   = s;
    assign key_raw[KEY_P]   = p;
    assign key_raw[KEY_R]   = r;
    assign key_raw[KEY_ESC] = esc;
    assign key_raw[KEY_UP]  = up;
    assign key_raw[KEY_DN]  = dn;
    assign key_raw[KEY_LF]  = lf;
    assign key_raw[KEY_RT]  = rt;

    key_edge_sync #(
        .W (NUM_KEYS)
    ) u_keys (
        .clk       (clk100Mhz),
        .srst      (reset),
        .key_async (key_raw),
        .key_event (key_evt)
    );

    // Pick one direction request per cycle: up > dn > lf > rt
    always_comb begin
        dir_valid = 1'b1;
        dir_sel   = DIR_RT;
        if (key_evt[KEY_UP]) begin
            dir_sel = DIR_UP;
        end else if (key_evt[KEY_DN]) begin
            dir_sel = DIR_DN;
        end else if (key_evt[KEY_LF]) begin
            dir_sel = DIR_LF;
        end else if (key_evt[KEY_RT]) begin
            dir_sel = DIR_RT;
        end else begin
            dir_valid = 1'b0;
        end
    end

    // Game FSM, move counter and direction commit.
    // Only events meaningful in the current state compete, so priority
    // esc > collide > s > p > r reduces to esc over everything and
    // collide over p while running.
    always_comb begin
        state_next   = state_reg;
        dir_next     = dir_reg;
        pending_next = pending_reg;
        cnt_next     = cnt_reg;
        tick_next    = 1'b0;
        clear_next   = 1'b0;

        if (key_evt[KEY_ESC]) begin
            // Quit: back to idle, counter discarded, no board clear
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    // Reversal is judged against the committed direction,
                    // so the last non-reverse press before a tick wins.
                    if (dir_valid && !is_reverse(dir_sel, dir_reg)) begin
                        pending_next = dir_sel;
                    end

                    if (collide) begin
                        state_next = ST_OVER;
                    end else if (key_evt[KEY_P]) begin
                        state_next = ST_PAUSE;
                    end

                    // A pause holds the count; a collision still lets this
                    // cycle's tick fire and the counter then stays frozen in OVER.
                    if (collide || !key_evt[KEY_P]) begin
                        if (cnt_reg == CNT_LAST) begin
                            cnt_next  = '0;
                            tick_next = 1'b1;
                            dir_next  = pending_next;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                end

                ST_PAUSE: begin
                    if (key_evt[KEY_R]) begin
                        state_next = ST_RUN;
                    end
                end

                default: begin
                    // IDLE or OVER: a start press begins a fresh game
                    if (key_evt[KEY_S]) begin
                        state_next   = ST_RUN;
                        clear_next   = 1'b1;
                        dir_next     = DIR_RT;
                        pending_next = DIR_RT;
                        cnt_next     = '0;
                    end
                end
            endcase
        end
    end

    // Controller state registers
    always_ff @(posedge clk100Mhz) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            dir_reg     <= DIR_RT;
            pending_reg <= DIR_RT;
            cnt_reg     <= '0;
            tick_reg    <= 1'b0;
            clear_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dir_reg     <= dir_next;
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
            tick_reg    <= tick_next;
            clear_reg   <= clear_next;
        end
    end

    assign state     = state_reg;
    assign dir       = dir_reg;
    assign move_tick = tick_reg;
    assign clear     = clear_reg;
    assign running   = (state_reg == ST_RUN);

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with MOVE_DIV = 8.
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       s, p, r, esc, up, dn, lf, rt, collide;
    logic [1:0] state, dir;
    logic       move_tick, clear, running;

    int checks   = 0;
    int failures = 0;

    snake_game_ctrl #(
        .MOVE_DIV (8),
        .CTR_W    (4)
    ) dut (
        .clk100Mhz (clk),
        .reset     (reset),
        .s         (s),
        .p         (p),
        .r         (r),
        .esc       (esc),
        .up        (up),
        .dn        (dn),
        .lf        (lf),
        .rt        (rt),
        .collide   (collide),
        .state     (state),
        .dir       (dir),
        .move_tick (move_tick),
        .clear     (clear),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance n clock edges and settle 1 ns past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Steps until move_tick is seen; n = -1 if the budget runs out
    task automatic wait_tick(input int max_cyc, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (move_tick !== 1'b1 && n < max_cyc);
        if (move_tick !== 1'b1) n = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, bad, tick_err, clr_err, first_tick;

        reset = 1'b1;
        {s, p, r, esc, up, dn, lf, rt, collide} = '0;
        step(3);
        reset = 1'b0;
        step(1);
        check("rst_state", int'(state), 0);
        check("rst_dir", int'(dir), 3);
        check("rst_tick", int'(move_tick), 0);
        check("rst_clear", int'(clear), 0);
        check("rst_running", int'(running), 0);

        // Idle for 20 cycles: nothing moves
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (state !== 2'b00 || dir !== 2'b11 || move_tick !== 1'b0 || clear !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);

        // Start: s held 50 cycles, clear 4 cycles after rise
        s = 1'b1;
        step(3);
        check("start_clear_early", int'(clear), 0);
        step(1);
        check("start_clear", int'(clear), 1);
        check("start_state", int'(state), 1);
        check("start_running", int'(running), 1);
        tick_err = 0; clr_err = 0; first_tick = -1;
        for (int i = 1; i <= 46; i++) begin
            step(1);
            if (move_tick !== ((i % 8) == 0)) tick_err++;
            if (move_tick === 1'b1 && first_tick < 0) first_tick = i;
            if (clear !== 1'b0) clr_err++;
        end
        s = 1'b0;
        check("first_tick", first_tick, 8);
        check("tick_period", tick_err, 0);
        check("clear_single", clr_err, 0);

        // Direction: lf is the reverse of RT and is dropped
        wait_tick(20, n);
        lf = 1'b1; step(3); lf = 1'b0;
        wait_tick(20, n);
        check("lf_tick_pos", n, 5);
        check("lf_rejected", int'(dir), 3);
        // up then dn: both valid against committed RT, last wins
        up = 1'b1; step(3); up = 1'b0;
        dn = 1'b1; step(3); dn = 1'b0;
        check("dir_before_tick", int'(dir), 3);
        wait_tick(20, n);
        check("updn_tick_pos", n, 2);
        check("updn_dir", int'(dir), 1);
        // lf then up: up is reverse of committed DN, so lf stays pending
        lf = 1'b1; step(3); lf = 1'b0;
        up = 1'b1; step(3); up = 1'b0;
        wait_tick(20, n);
        check("rev_vs_committed", int'(dir), 2);

        // Pause with counter at 5, resume, 3 run cycles to next tick
        step(2);
        p = 1'b1; step(3);
        check("pre_pause_state", int'(state), 1);
        step(1);
        p = 1'b0;
        check("pause_state", int'(state), 2);
        check("pause_running", int'(running), 0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (move_tick !== 1'b0 || state !== 2'b10) bad++;
        end
        check("pause_quiet", bad, 0);
        r = 1'b1; step(3); r = 1'b0;
        check("resume_early", int'(state), 2);
        step(1);
        check("resume_state", int'(state), 1);
        wait_tick(20, n);
        check("resume_tick_pos", n, 3);

        // Collision ends the game, ticks stop
        collide = 1'b1; step(1); collide = 1'b0;
        check("over_state", int'(state), 3);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (move_tick !== 1'b0 || state !== 2'b11) bad++;
        end
        check("over_quiet", bad, 0);
        // Restart from OVER
        s = 1'b1; step(3);
        check("restart_clear_early", int'(clear), 0);
        step(1);
        s = 1'b0;
        check("restart_clear", int'(clear), 1);
        check("restart_state", int'(state), 1);
        check("restart_dir", int'(dir), 3);
        wait_tick(20, n);
        check("restart_tick_pos", n, 8);

        // esc and p together: esc wins, no pause
        esc = 1'b1; p = 1'b1; step(4);
        check("esc_state", int'(state), 0);
        check("esc_no_clear", int'(clear), 0);
        esc = 1'b0; p = 1'b0;
        step(2);
        check("esc_stays_idle", int'(state), 0);

        // Reset mid-run just before a tick, with a key in flight
        s = 1'b1; step(4); s = 1'b0;
        check("rerun_state", int'(state), 1);
        dn = 1'b1; step(3); dn = 1'b0;
        wait_tick(20, n);
        check("rerun_dir", int'(dir), 1);
        step(7);
        reset = 1'b1; lf = 1'b1;
        step(1);
        check("midrst_state", int'(state), 0);
        check("midrst_dir", int'(dir), 3);
        check("midrst_tick", int'(move_tick), 0);
        check("midrst_clear", int'(clear), 0);
        check("midrst_running", int'(running), 0);
        step(1);
        reset = 1'b0;
        step(2); lf = 1'b0;
        step(5);
        check("post_rst_idle", int'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
